// File: rtl/al_clksw_ctrl.sv
// al_clksw_ctrl: break-before-make clock-source switch sequencer.
// Drops the old gate, waits a dead time, raises the new gate, confirming each step on synchronised acks.
module al_clksw_ctrl #(
   parameter int NCH       = 4,
   parameter int SELW      = 2,
   parameter int DEAD_CYC  = 4,
   parameter int ACK_TO    = 16,
   parameter int PRESELECT = NCH,
   parameter int INITOUT   = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic [SELW-1:0] req_sel,
   output logic            req_ready,
   input  logic [NCH-1:0]  ce,
   input  logic [NCH-1:0]  ignr,
   input  logic [NCH-1:0]  gate_ack,
   input  logic            err_clr,
   output logic [NCH-1:0]  gate_en,
   output logic [SELW-1:0] active_sel,
   output logic            active_vld,
   output logic            busy,
   output logic [1:0]      err,
   output logic            initout
);

   typedef enum logic [1:0] {IDLE, DROP, DEAD, RAISE} state_t;

   localparam logic [7:0]      TO_MAX   = 8'(ACK_TO - 1);
   localparam logic [7:0]      DEAD_MAX = 8'(DEAD_CYC - 1);
   localparam bit              PRE_ON   = (PRESELECT < NCH);
   localparam logic [SELW-1:0] PRE_SEL  = PRE_ON ? SELW'(PRESELECT) : '0;

   function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] s);
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) v[i] = (s == SELW'(i));
      return v;
   endfunction

   state_t          state;
   logic [7:0]      cnt;
   logic [SELW-1:0] sel_reg;
   logic [SELW-1:0] new_sel;
   logic            en_reg;
   logic [NCH-1:0]  gate_q;
   logic [NCH-1:0]  ack_m;
   logic [NCH-1:0]  ack_s;

   logic req_bad;
   logic req_same;
   logic drop_done;
   logic raise_done;
   logic cnt_to;
   logic to_ev;
   logic rng_ev;

   // req_valid/req_ready: a request transfers on an edge where both are high; req_ready is high only in IDLE.
   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign active_sel = sel_reg;
   assign initout    = 1'(INITOUT);
   assign gate_en    = gate_q & ce;

   assign req_bad    = int'(req_sel) >= NCH;
   assign req_same   = (req_sel == sel_reg) && active_vld;
   assign drop_done  = !ack_s[sel_reg] || ignr[sel_reg];
   assign raise_done = ack_s[sel_reg] || ignr[sel_reg];
   assign cnt_to     = (cnt == TO_MAX);
   assign to_ev      = cnt_to && (((state == DROP) && !drop_done) ||
                                  ((state == RAISE) && !raise_done));
   assign rng_ev     = (state == IDLE) && req_valid && req_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_m <= '0;
         ack_s <= '0;
      end else begin
         ack_m <= gate_ack;
         ack_s <= ack_m;
      end
   end

   // A fresh error event in the same cycle as err_clr survives the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 2'b00;
      else     err <= (err_clr ? 2'b00 : err) | {rng_ev, to_ev};
   end

   // gate_q is updated on the same edge as en_reg/sel_reg so each enable is a clean flop output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sel_reg    <= PRE_SEL;
         new_sel    <= '0;
         en_reg     <= PRE_ON;
         active_vld <= PRE_ON;
         gate_q     <= PRE_ON ? onehot(PRE_SEL) : '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (req_valid && !req_bad && !req_same) begin
                  new_sel <= req_sel;
                  if (en_reg) begin
                     en_reg <= 1'b0;
                     gate_q <= '0;
                     state  <= DROP;
                  end else begin
                     state  <= DEAD;
                  end
               end
            end
            DROP: begin
               // A timed-out drop also leaves the old channel unconfirmed.
               if (drop_done || cnt_to) begin
                  active_vld <= 1'b0;
                  cnt        <= '0;
                  state      <= DEAD;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DEAD: begin
               if (cnt == DEAD_MAX) begin
                  sel_reg <= new_sel;
                  en_reg  <= 1'b1;
                  gate_q  <= onehot(new_sel);
                  cnt     <= '0;
                  state   <= RAISE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RAISE: begin
               if (raise_done) begin
                  active_vld <= 1'b1;
                  cnt        <= '0;
                  state      <= IDLE;
               end else if (cnt_to) begin
                  en_reg     <= 1'b0;
                  gate_q     <= '0;
                  active_vld <= 1'b0;
                  cnt        <= '0;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_al_clksw_ctrl.sv
// Bench for al_clksw_ctrl: a 4-channel instance driven against a behavioural switch model,
// plus a 3-channel instance without preselect for range, no-op and mid-switch reset cases.
module tb_al_clksw_ctrl;

   localparam int DEAD_CYC = 4;
   localparam int ACK_TO   = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [1:0] req_sel;
   logic       req_ready;
   logic [3:0] ce;
   logic [3:0] ignr;
   logic [3:0] gate_ack;
   logic       err_clr;
   logic [3:0] gate_en;
   logic [1:0] active_sel;
   logic       active_vld;
   logic       busy;
   logic [1:0] err;
   logic       initout;

   logic       rst3;
   logic       req_valid3;
   logic [1:0] req_sel3;
   logic       req_ready3;
   logic [2:0] ce3;
   logic [2:0] ignr3;
   logic [2:0] gate_ack3;
   logic       err_clr3;
   logic [2:0] gate_en3;
   logic [1:0] active_sel3;
   logic       active_vld3;
   logic       busy3;
   logic [1:0] err3;
   logic       initout3;

   int checks = 0;
   int errors = 0;

   // gate-cell model: ack follows gate_en after lat edges, stuck channels never ack
   int         lat = 2;
   logic [3:0] stuck = 4'b0000;
   logic [3:0] hist [8];

   // switch model state
   logic [1:0] m_sel;
   logic       m_vld;
   logic       m_en;
   logic [1:0] m_err;

   al_clksw_ctrl #(.NCH(4), .SELW(2), .DEAD_CYC(DEAD_CYC), .ACK_TO(ACK_TO),
                   .PRESELECT(0), .INITOUT(0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(req_ready), .ce(ce), .ignr(ignr), .gate_ack(gate_ack),
      .err_clr(err_clr), .gate_en(gate_en), .active_sel(active_sel),
      .active_vld(active_vld), .busy(busy), .err(err), .initout(initout));

   al_clksw_ctrl #(.NCH(3), .SELW(2), .DEAD_CYC(DEAD_CYC), .ACK_TO(ACK_TO),
                   .PRESELECT(3), .INITOUT(1)) dut3 (
      .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_sel(req_sel3),
      .req_ready(req_ready3), .ce(ce3), .ignr(ignr3), .gate_ack(gate_ack3),
      .err_clr(err_clr3), .gate_en(gate_en3), .active_sel(active_sel3),
      .active_vld(active_vld3), .busy(busy3), .err(err3), .initout(initout3));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = gate_en;
      gate_ack = hist[lat] & ~stuck;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      checks++;
      if (!$onehot0(gate_en) || !$onehot0(gate_en3)) begin
         errors++;
         $display("FAIL onehot: gate_en=%b gate_en3=%b expected zero-or-one-hot", gate_en, gate_en3);
      end
   endtask

   function automatic logic ack_ok(input logic [1:0] ch);
      return ce[ch] && !stuck[ch];
   endfunction

   // Phase lengths of one switch: drop, dead, raise; updates the model afterwards.
   task automatic predict(input logic [1:0] sel, output int eb, output int ed, output int er);
      bit to_flag;
      eb = 0; ed = 0; er = 0;
      if (m_vld && sel == m_sel) return;
      if (m_en) ed = (ignr[m_sel] || !ack_ok(m_sel)) ? 1 : lat + 3;
      to_flag = !ignr[sel] && !ack_ok(sel);
      er = ignr[sel] ? 1 : (to_flag ? ACK_TO : lat + 3);
      eb = ed + DEAD_CYC + er;
      m_sel = sel;
      m_en  = !to_flag;
      m_vld = !to_flag;
      if (to_flag) m_err[0] = 1'b1;
   endtask

   task automatic send_req(input logic [1:0] sel, output int nb, output int nl);
      req_valid = 1'b1;
      req_sel   = sel;
      tick();
      req_valid = 1'b0;
      nb = 0;
      nl = 0;
      while (busy === 1'b1 && nb < 300) begin
         nb++;
         if (gate_en != 4'b0000) nl++;
         tick();
      end
   endtask

   task automatic run_req(input logic [1:0] sel, input string tag);
      int eb, ed, er, nb, nl;
      logic [3:0] eg;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b expected 1", tag, req_ready); end
      predict(sel, eb, ed, er);
      send_req(sel, nb, nl);
      checks++;
      if (nb != eb) begin errors++; $display("FAIL %s busy_cycles sel=%0d: got %0d expected %0d", tag, sel, nb, eb); end
      checks++;
      if (nl != (ce[sel] ? er : 0)) begin
         errors++; $display("FAIL %s raise_cycles sel=%0d: got %0d expected %0d", tag, sel, nl, ce[sel] ? er : 0);
      end
      eg = m_en ? ((4'b0001 << m_sel) & ce) : 4'b0000;
      checks++;
      if (gate_en !== eg) begin errors++; $display("FAIL %s gate_en: got %b expected %b", tag, gate_en, eg); end
      checks++;
      if (active_sel !== m_sel) begin errors++; $display("FAIL %s active_sel: got %0d expected %0d", tag, active_sel, m_sel); end
      checks++;
      if (active_vld !== m_vld) begin errors++; $display("FAIL %s active_vld: got %b expected %b", tag, active_vld, m_vld); end
      checks++;
      if (err !== m_err) begin errors++; $display("FAIL %s err: got %b expected %b", tag, err, m_err); end
      repeat (8) tick();
   endtask

   task automatic send_req3(input logic [1:0] sel, output int nb);
      req_valid3 = 1'b1;
      req_sel3   = sel;
      tick();
      req_valid3 = 1'b0;
      nb = 0;
      while (busy3 === 1'b1 && nb < 300) begin
         nb++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rst3 = 1'b1;
      repeat (3) tick();
      checks++;
      if (gate_en !== 4'b0001) begin errors++; $display("FAIL reset gate_en: got %b expected 0001", gate_en); end
      checks++;
      if (active_vld !== 1'b1 || active_sel !== 2'd0) begin
         errors++; $display("FAIL reset active: got vld=%b sel=%0d expected vld=1 sel=0", active_vld, active_sel);
      end
      checks++;
      if (err !== 2'b00 || busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL reset status: got err=%b busy=%b ready=%b expected 00 0 1", err, busy, req_ready);
      end
      checks++;
      if (gate_en3 !== 3'b000 || active_vld3 !== 1'b0 || active_sel3 !== 2'd0) begin
         errors++; $display("FAIL reset3: got gate=%b vld=%b sel=%0d expected 000 0 0", gate_en3, active_vld3, active_sel3);
      end
      checks++;
      if (initout !== 1'b0 || initout3 !== 1'b1) begin
         errors++; $display("FAIL initout: got %b/%b expected 0/1", initout, initout3);
      end
      rst = 1'b0; rst3 = 1'b0;
      repeat (8) tick();
      checks++;
      if (gate_en !== 4'b0001 || active_vld !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset: got gate=%b vld=%b busy=%b expected 0001 1 0", gate_en, active_vld, busy);
      end
      m_sel = 2'd0; m_vld = 1'b1; m_en = 1'b1; m_err = 2'b00;
   endtask

   task automatic test_ignr_switch();
      int eb, ed, er;
      logic [3:0] eg;
      ignr = 4'hF;
      predict(2'd2, eb, ed, er);
      req_valid = 1'b1;
      req_sel   = 2'd2;
      tick();
      req_valid = 1'b0;
      for (int e = 1; e <= eb + 1; e++) begin
         eg = (e <= ed + DEAD_CYC) ? 4'b0000 : 4'b0100;
         checks++;
         if (gate_en !== eg) begin errors++; $display("FAIL ignr_switch gate_en edge %0d: got %b expected %b", e, gate_en, eg); end
         checks++;
         if (e <= eb) begin
            if (busy !== 1'b1) begin errors++; $display("FAIL ignr_switch busy edge %0d: got %b expected 1", e, busy); end
         end else begin
            if (busy !== 1'b0 || active_vld !== 1'b1 || req_ready !== 1'b1) begin
               errors++; $display("FAIL ignr_switch done edge %0d: got busy=%b vld=%b ready=%b expected 0 1 1", e, busy, active_vld, req_ready);
            end
         end
         tick();
      end
      repeat (8) tick();
   endtask

   task automatic test_ack_switch();
      ignr = 4'h0;
      lat  = 2;
      run_req(2'd3, "ack_switch");
   endtask

   task automatic test_timeout();
      ignr  = 4'h0;
      stuck = 4'b0010;
      repeat (8) tick();
      run_req(2'd1, "timeout");
      checks++;
      if (err !== 2'b01 || busy !== 1'b0) begin errors++; $display("FAIL timeout sticky: got err=%b busy=%b expected 01 0", err, busy); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      m_err = 2'b00;
      tick();
      checks++;
      if (err !== 2'b00) begin errors++; $display("FAIL timeout err_clr: got %b expected 00", err); end
      stuck = 4'b0000;
      repeat (8) tick();
   endtask

   task automatic test_back_to_back();
      int eb1, eb2, ed, er, n;
      ignr = 4'hF;
      run_req(2'd2, "b2b_setup");
      predict(2'd0, eb1, ed, er);
      predict(2'd3, eb2, ed, er);
      req_valid = 1'b1;
      req_sel   = 2'd0;
      tick();
      req_sel = 2'd3;
      n = 0;
      while (busy === 1'b1 && n < 300) begin n++; tick(); end
      checks++;
      if (n != eb1) begin errors++; $display("FAIL b2b first_busy: got %0d expected %0d", n, eb1); end
      checks++;
      if (req_ready !== 1'b1 || active_sel !== 2'd0) begin
         errors++; $display("FAIL b2b idle_gap: got ready=%b sel=%0d expected 1 0", req_ready, active_sel);
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b second_accept: got busy=%b expected 1", busy); end
      n = 0;
      while (busy === 1'b1 && n < 300) begin n++; tick(); end
      checks++;
      if (n != eb2) begin errors++; $display("FAIL b2b second_busy: got %0d expected %0d", n, eb2); end
      checks++;
      if (gate_en !== 4'b1000 || active_sel !== 2'd3 || active_vld !== 1'b1) begin
         errors++; $display("FAIL b2b final: got gate=%b sel=%0d vld=%b expected 1000 3 1", gate_en, active_sel, active_vld);
      end
      repeat (8) tick();
   endtask

   task automatic test_random();
      ce = 4'($urandom_range(1, 15));
      for (int k = 0; k < 24; k++) begin
         ignr = 4'($urandom);
         lat  = $urandom_range(0, 3);
         if ((k % 6) == 0) stuck = 4'($urandom);
         repeat (8) tick();
         run_req(2'($urandom_range(0, 3)), "random");
      end
      ce = 4'hF; stuck = 4'h0; ignr = 4'hF;
      repeat (8) tick();
   endtask

   task automatic test_nch3();
      int n;
      send_req3(2'd1, n);
      checks++;
      if (n != DEAD_CYC + 1) begin errors++; $display("FAIL nch3 first_busy: got %0d expected %0d", n, DEAD_CYC + 1); end
      checks++;
      if (gate_en3 !== 3'b010 || active_vld3 !== 1'b1 || active_sel3 !== 2'd1) begin
         errors++; $display("FAIL nch3 select: got gate=%b vld=%b sel=%0d expected 010 1 1", gate_en3, active_vld3, active_sel3);
      end
      send_req3(2'd3, n);
      checks++;
      if (n != 0 || err3 !== 2'b10 || gate_en3 !== 3'b010) begin
         errors++; $display("FAIL nch3 range: got busy_cycles=%0d err=%b gate=%b expected 0 10 010", n, err3, gate_en3);
      end
      send_req3(2'd1, n);
      checks++;
      if (n != 0 || active_vld3 !== 1'b1 || gate_en3 !== 3'b010) begin
         errors++; $display("FAIL nch3 noop: got busy_cycles=%0d vld=%b gate=%b expected 0 1 010", n, active_vld3, gate_en3);
      end
      req_valid3 = 1'b1; req_sel3 = 2'd3; err_clr3 = 1'b1;
      tick();
      req_valid3 = 1'b0; err_clr3 = 1'b0;
      checks++;
      if (err3 !== 2'b10) begin errors++; $display("FAIL nch3 set_wins: got %b expected 10", err3); end
      err_clr3 = 1'b1;
      tick();
      err_clr3 = 1'b0;
      checks++;
      if (err3 !== 2'b00) begin errors++; $display("FAIL nch3 err_clr: got %b expected 00", err3); end
   endtask

   task automatic test_reset_mid();
      int n;
      send_req3(2'd0, n);
      checks++;
      if (n != 1 + DEAD_CYC + 1 || gate_en3 !== 3'b001) begin
         errors++; $display("FAIL rst_mid setup: got busy_cycles=%0d gate=%b expected %0d 001", n, gate_en3, DEAD_CYC + 2);
      end
      req_valid3 = 1'b1; req_sel3 = 2'd2;
      tick();
      req_valid3 = 1'b0;
      tick();
      checks++;
      if (busy3 !== 1'b1 || gate_en3 !== 3'b000) begin
         errors++; $display("FAIL rst_mid dead: got busy=%b gate=%b expected 1 000", busy3, gate_en3);
      end
      #2 rst3 = 1'b1;
      #1;
      checks++;
      if (gate_en3 !== 3'b000 || active_vld3 !== 1'b0 || busy3 !== 1'b0 || req_ready3 !== 1'b1 || active_sel3 !== 2'd0) begin
         errors++; $display("FAIL rst_mid async: got gate=%b vld=%b busy=%b ready=%b sel=%0d expected 000 0 0 1 0",
                            gate_en3, active_vld3, busy3, req_ready3, active_sel3);
      end
      tick();
      rst3 = 1'b0;
      repeat (3) tick();
      checks++;
      if (gate_en3 !== 3'b000 || active_vld3 !== 1'b0 || busy3 !== 1'b0) begin
         errors++; $display("FAIL rst_mid release: got gate=%b vld=%b busy=%b expected 000 0 0", gate_en3, active_vld3, busy3);
      end
   endtask

   initial begin
      req_valid = 1'b0; req_sel = 2'd0; ce = 4'hF; ignr = 4'h0; err_clr = 1'b0;
      req_valid3 = 1'b0; req_sel3 = 2'd0; ce3 = 3'b111; ignr3 = 3'b111;
      gate_ack3 = 3'b000; err_clr3 = 1'b0;
      test_reset();
      test_ignr_switch();
      test_ack_switch();
      test_timeout();
      test_back_to_back();
      test_random();
      test_nch3();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
